// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of the data-bus controller: checks legality and
// alignment, drives the bus strobes, and returns extended load data or an error response.
module load_store_unit #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic                  bus_rd,
  output logic                  bus_wd,
  output logic [1:0]            bus_size,
  output logic [ADDR_WIDTH-1:0] bus_addr_in,
  output logic [ADDR_WIDTH-1:0] bus_addr_out,
  output logic [31:0]           bus_data_in,
  input  logic [31:0]           bus_data_out,
  input  logic                  bus_busy
);

  typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_COMMIT, RESP, ERR} state_t;

  localparam logic [2:0] RL = 3'(READ_LATENCY);

  state_t      state;
  logic [2:0]  op_f3;
  logic [2:0]  cnt;
  logic        wd_arm;
  logic [1:0]  req_size;
  logic        req_mis;
  logic        req_ill;
  logic [31:0] ld_ext;

  always_comb begin
    req_size = req_funct3[1:0];
    req_mis  = (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    req_ill  = req_we ? (req_funct3 > 3'd2)
                      : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
  end

  always_comb begin
    ld_ext = bus_data_out;
    case (op_f3)
      3'd0:    ld_ext = {{24{bus_data_out[7]}}, bus_data_out[7:0]};
      3'd1:    ld_ext = {{16{bus_data_out[15]}}, bus_data_out[15:0]};
      3'd4:    ld_ext = {24'b0, bus_data_out[7:0]};
      3'd5:    ld_ext = {16'b0, bus_data_out[15:0]};
      default: ld_ext = bus_data_out;
    endcase
  end

  // The commit strobe is withheld combinationally while the controller is busy so it
  // fires exactly once, in the first non-busy WR_COMMIT cycle.
  assign bus_wd = wd_arm & ~bus_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      op_f3           <= 3'd0;
      cnt             <= 3'd0;
      wd_arm          <= 1'b0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_data       <= 32'd0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      bus_rd          <= 1'b0;
      bus_size        <= 2'd0;
      bus_addr_in     <= '0;
      bus_addr_out    <= '0;
      bus_data_in     <= 32'd0;
    end else begin
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          op_f3     <= req_funct3;
          req_ready <= 1'b0;
          cnt       <= 3'd0;
          if (req_ill || req_mis) begin
            state           <= ERR;
            resp_valid      <= 1'b1;
            resp_illegal    <= req_ill;
            resp_misaligned <= ~req_ill;
          end else if (!req_we) begin
            state        <= READ;
            bus_rd       <= 1'b1;
            bus_addr_out <= req_addr;
            bus_size     <= req_size;
          end else begin
            state        <= WR_SETUP;
            bus_addr_in  <= req_addr;
            bus_addr_out <= req_addr;
            bus_size     <= req_size;
            bus_data_in  <= req_wdata;
          end
        end
        READ: if (!bus_busy) begin
          if (cnt == RL) begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_data    <= ld_ext;
            bus_rd       <= 1'b0;
            bus_addr_out <= '0;
            bus_size     <= 2'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR_SETUP: if (!bus_busy) begin
          state  <= WR_COMMIT;
          wd_arm <= 1'b1;
        end
        WR_COMMIT: if (!bus_busy) begin
          state        <= RESP;
          resp_valid   <= 1'b1;
          wd_arm       <= 1'b0;
          bus_addr_in  <= '0;
          bus_addr_out <= '0;
          bus_size     <= 2'd0;
          bus_data_in  <= 32'd0;
        end
        RESP, ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          resp_data <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data-bus controller, between the execute stage and the data RAM/register bus.
- Accepts one RV32I load or store per handshake and checks alignment and funct3 legality locally.
- Sequences the bus strobes to match the controller's 1-cycle registered read and read-modify-write store.
- Returns sign- or zero-extended load data, or an error response, to the core.

Parameters:
- READ_LATENCY, 1: cycles from stable bus_addr_out with bus_rd high until bus_data_out is valid; legal range 1..7.
- ADDR_WIDTH, 32: width of the address on the core side and the bus side.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- req_valid  in  1  core presents a memory operation.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; the operation has completed.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  qualified by resp_valid.
- resp_illegal  out  1  illegal funct3, qualified by resp_valid.
- bus_rd  out  1  read strobe to the controller.
- bus_wd  out  1  write strobe to the controller.
- bus_size  out  2  00 byte, 01 half, 10 word; drives both size_in and size_out.
- bus_addr_in  out  ADDR_WIDTH  write address.
- bus_addr_out  out  ADDR_WIDTH  read address.
- bus_data_in  out  32  write data.
- bus_data_out  in  32  read data from the controller, zero-extended by size.
- bus_busy  in  1  controller busy; stalls the unit.

Behaviour:
- Reset: while rst=0 at a clock edge:
  - state goes to IDLE and all counters clear;
  - req_ready=1;
  - resp_valid, resp_misaligned, resp_illegal, bus_rd and bus_wd are 0;
  - bus_size, both bus addresses, bus_data_in and resp_data are 0.
- Reset mid-operation abandons the operation with no response; a store not yet in WR_COMMIT never asserts bus_wd.
- Latched operation register: op, addr, wdata and size are captured on req_valid && req_ready.
  - Bus outputs are driven only from latched values.
  - In IDLE, ERR and RESP the bus outputs are 0.
- Alignment and legality checks, evaluated on the request at acceptance:
  - misaligned = (size==01 && addr[0]) || (size==10 && addr[1:0]!=0);
  - illegal = load funct3 in {3,6,7}, or store funct3 > 2;
  - illegal takes priority over misaligned.
- States:
  - IDLE: req_ready=1. On accept:
    - error → ERR;
    - load → READ;
    - store → WR_SETUP.
  - READ: bus_rd=1, bus_addr_out=addr, bus_size=size.
    - Counter cnt starts at 0 and increments each cycle bus_busy=0; it holds while busy.
    - When cnt==READ_LATENCY and bus_busy=0, capture the extended bus_data_out into resp_data → RESP.
  - WR_SETUP: bus_addr_in=bus_addr_out=addr, bus_size=size, bus_wd=0, bus_data_in=wdata.
    - One cycle, so the controller's read-modify-write shadow register loads.
    - Go to WR_COMMIT when bus_busy=0; otherwise hold.
  - WR_COMMIT: same drives with bus_wd=1 for exactly one cycle → RESP.
    - If bus_busy=1 on entry, bus_wd is held 0 and the state holds until not busy.
  - RESP: resp_valid=1 for one cycle; resp_data is held as captured (0 for stores) → IDLE.
  - ERR: resp_valid=1, the matching error flag=1, resp_data=0, no bus strobes → IDLE.
- Load extension of the captured data d:
  - LB = {{24{d[7]}}, d[7:0]};
  - LBU = {24'b0, d[7:0]};
  - LH = {{16{d[15]}}, d[15:0]};
  - LHU = {16'b0, d[15:0]};
  - LW = d.
- Latency with bus_busy=0, request accepted at cycle T:
  - load: resp_valid at T+READ_LATENCY+2;
  - store: resp_valid at T+3;
  - error: resp_valid at T+1.
- Back-to-back: req_ready is low from T+1 until the cycle after resp_valid. The next accept is earliest the cycle after RESP/ERR.
- Error flags and resp_data return to 0 the cycle after resp_valid.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 → req_ready=1, every other output 0, no bus_rd or bus_wd.
- SW addr=0x10, wdata=0xDEADBEEF:
  - WR_SETUP at T+1 (bus_wd=0);
  - bus_wd=1 only at T+2 with size=10;
  - resp_valid at T+3.
  - Then LW 0x10 → resp_data=0xDEADBEEF at T+3.
- Load extension with bus_data_out=0x00000080 on a byte read → LB gives 0xFFFFFF80, LBU gives 0x00000080. With 0x00008001 on a half read → LH gives 0xFFFF8001.
- LH addr=0x13 → resp_valid at T+1 with resp_misaligned=1, no bus strobe. funct3=3 load → resp_illegal=1, resp_misaligned=0.
- bus_busy=1 for 4 cycles during WR_SETUP → bus_wd stays 0 throughout and pulses exactly once after busy drops. For a read with READ_LATENCY=3 → resp_valid at T+5 plus the busy cycles.
- Reset mid-op: rst=0 in WR_SETUP → no bus_wd and no resp_valid; IDLE with req_ready=1 on the next cycle.
